// File: rtl/ssd_pkg.sv
// -----------------------------------------------------------------------------
// ssd_pkg
//   Shared definitions for the BCD-to-binary converter:
//     state_t         - converter FSM states (IDLE / SHIFT / FINISH)
//     BCD_ADJ_THRESH  - nibble value at or above which a correction is applied
//     BCD_ADJ_SUB     - correction subtracted from such a nibble
// -----------------------------------------------------------------------------
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_nibble_adj.sv
// -----------------------------------------------------------------------------
// bcd_nibble_adj
//   Combinational correction of one BCD nibble after a right shift.
//   A nibble that received a bit from the digit above it holds a value of
//   8 or more; subtracting 3 turns that "16/2 = 8" weight into "10/2 = 5".
// Ports:
//   din  [3:0] - shifted nibble
//   dout [3:0] - corrected nibble (din >= 8 ? din - 3 : din)
// -----------------------------------------------------------------------------
module bcd_nibble_adj
    import ssd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THRESH) ? (din - BCD_ADJ_SUB) : din;

endmodule

// File: rtl/bcd_bin_conv.sv
// -----------------------------------------------------------------------------
// bcd_bin_conv
//   Sequential packed-BCD to binary converter (reverse double-dabble).
//   A START in IDLE captures BCDIN; BIN_W shift/adjust iterations move the
//   value into the binary accumulator; a FINISH cycle registers the result
//   onto BIN and pulses DONE. START is ignored while BUSY is high.
//
//   Handshake: START is a single-cycle request accepted only in IDLE (BUSY=0);
//   DONE is a one-cycle pulse coincident with BIN being updated and BUSY
//   falling, so a new START may be presented in the very next cycle.
//
// Parameters:
//   DIGITS - number of packed BCD digits on BCDIN
//   BIN_W  - binary output width (10**DIGITS - 1 must fit)
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   synchronous, active-high reset
//   START in   conversion request
//   BCDIN in   [4*DIGITS-1:0] packed BCD, digit 0 in [3:0]
//   BIN   out  [BIN_W-1:0] converted value, stable between DONE pulses
//   BUSY  out  conversion in progress
//   DONE  out  one-cycle pulse when BIN is updated
//   ERR   out  invalid-digit flag
//
// Build option:
//   BCD_DIGIT_CHECK_EN - when defined, captured nibbles > 9 make the FINISH
//   cycle drive BIN=0 and ERR=1 (ERR held until next DONE or reset).
//   When undefined, ERR is tied to 0 and invalid nibbles are converted as-is.
// -----------------------------------------------------------------------------
module bcd_bin_conv
    import ssd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   BCDIN,
    output logic [BIN_W-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [BIN_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    // One iteration: shift {bcd, acc} right as a single register, then
    // correct every BCD nibble.
    logic [BCD_W+BIN_W-1:0] shr;
    logic [BCD_W-1:0]       bcd_adj;

    assign shr = {bcd_q, acc_q} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .din  (shr[BIN_W + 4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_pend_q, err_pend_d;
    logic err_q,      err_d;
    logic digit_bad;

    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCDIN[4*i +: 4] > 4'd9) digit_bad = 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        err_pend_d = err_pend_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    bcd_d   = BCDIN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
                    err_pend_d = digit_bad;
`endif
                end
            end
            SHIFT: begin
                bcd_d = bcd_adj;
                acc_d = shr[BIN_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) state_d = FINISH;
            end
            FINISH: begin
                bin_d   = acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef BCD_DIGIT_CHECK_EN
                err_d = err_pend_q;
                if (err_pend_q) bin_d = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD_DIGIT_CHECK_EN
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
`endif
        end
    end

    assign BIN  = bin_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
